// File: rtl/twos_to_signmag_receiver_pkg.sv
// twos_to_signmag_receiver_pkg: shared state encoding, default word width, counter sizing
//   S_RECV  collecting serial bits
//   S_HOLD  parallel result presented, waiting for consumer
package twos_to_signmag_receiver_pkg;
    typedef enum logic {S_RECV = 1'b0, S_HOLD = 1'b1} state_t;
    localparam int DEF_WIDTH = 8;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/serial_negate_cell.sv
// serial_negate_cell: LSB-first serial two's-complement negation (copy up to first 1, invert after)
//   clk, rst  clock, sync active-high reset
//   clr       word end, forgets the seen-one flag (wins over en)
//   en        a bit is accepted this cycle
//   b         incoming serial bit
//   nb        negated bit for b, combinational
module serial_negate_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic b,
    output logic nb
);
    logic seen_one_q, seen_one_d;
    always_comb begin
        nb = seen_one_q ? ~b : b;
        seen_one_d = clr ? 1'b0 : (en ? (seen_one_q | b) : seen_one_q);
    end
    always_ff @(posedge clk) begin
        if (rst) seen_one_q <= 1'b0;
        else     seen_one_q <= seen_one_d;
    end
endmodule

// File: rtl/twos_to_signmag_receiver.sv
// twos_to_signmag_receiver: serial LSB-first two's-complement word in, parallel sign-magnitude out
//   clk, rst   clock, sync active-high reset
//   inp        serial data bit, LSB first
//   in_valid   inp valid this cycle
//   in_ready   ready for a bit (state only)
//   out_valid  result held
//   out_ready  consumer accepts result
//   sign       1 = negative
//   mag        |x|
//   ovf        |x| = 2^(WIDTH-1), not representable in mag
module twos_to_signmag_receiver
    import twos_to_signmag_receiver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign,
    output logic [WIDTH-2:0] mag,
    output logic             ovf
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] raw_q, raw_d, neg_q, neg_d;
    logic sign_q, sign_d, ovf_q, ovf_d;
    logic [WIDTH-2:0] mag_q, mag_d;
    logic acc, word_end, nb;
    assign in_ready  = (state_q == S_RECV);
    assign out_valid = (state_q == S_HOLD);
    assign acc       = in_valid & in_ready;
    assign sign      = sign_q;
    assign mag       = mag_q;
    assign ovf       = ovf_q;
    serial_negate_cell u_neg (
        .clk (clk),
        .rst (rst),
        .clr (word_end),
        .en  (acc),
        .b   (inp),
        .nb  (nb)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        raw_d    = raw_q;
        neg_d    = neg_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        ovf_d    = ovf_q;
        word_end = 1'b0;
        if (state_q == S_RECV) begin
            if (acc) begin
                raw_d = {inp, raw_q[WIDTH-1:1]};
                neg_d = {nb, neg_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // MSB: decide on the freshly shifted values; nb is the negated MSB
                    word_end = 1'b1;
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    sign_d   = inp;
                    mag_d    = inp ? neg_d[WIDTH-2:0] : raw_d[WIDTH-2:0];
                    ovf_d    = inp & nb;
                end
            end
        end else if (out_ready) begin
            state_d = S_RECV;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RECV;
            cnt_q   <= '0;
            raw_q   <= '0;
            neg_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raw_q   <= raw_d;
            neg_q   <= neg_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_twos_to_signmag_receiver.sv
// tb_twos_to_signmag_receiver: directed vectors for the serial sign-magnitude receiver, WIDTH=8
module tb_twos_to_signmag_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inp = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, sign, ovf;
    logic [6:0] mag;
    int n_chk = 0;
    int n_pass = 0;

    twos_to_signmag_receiver #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .mag       (mag),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ((i % 3) + 1) tick();
            end
            chk("ov_pre", 32'(out_valid), 0);
            inp = w[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic s, input logic [6:0] m, input logic o);
        chk({tag, "_ov"}, 32'(out_valid), 1);
        chk({tag, "_ir"}, 32'(in_ready), 0);
        chk({tag, "_sign"}, 32'(sign), 32'(s));
        chk({tag, "_mag"}, 32'(mag), 32'(m));
        chk({tag, "_ovf"}, 32'(ovf), 32'(o));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ir", 32'(in_ready), 1);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_sign", 32'(sign), 0);
        chk("rst_mag", 32'(mag), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        send_word(8'hFB, 1'b0);
        chk_out("m5", 1'b1, 7'd5, 1'b0);
        tick();
        chk("m5_ir_after", 32'(in_ready), 1);
        chk("m5_ov_after", 32'(out_valid), 0);
        send_word(8'h2A, 1'b1);
        chk_out("p42", 1'b0, 7'd42, 1'b0);
        tick();
        send_word(8'h80, 1'b0);
        chk_out("mneg", 1'b1, 7'd0, 1'b1);
        tick();
        send_word(8'h00, 1'b0);
        chk_out("zero", 1'b0, 7'd0, 1'b0);
        tick();
        out_ready = 1'b0;
        send_word(8'h81, 1'b0);
        for (int i = 0; i < 5; i++) begin
            inp = i[0];
            in_valid = ~i[0];
            tick();
            chk("hold_ir", 32'(in_ready), 0);
            chk("hold_ov", 32'(out_valid), 1);
            chk("hold_sign", 32'(sign), 1);
            chk("hold_mag", 32'(mag), 127);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rel_ov", 32'(out_valid), 0);
        chk("rel_ir", 32'(in_ready), 1);
        chk("rel_mag_kept", 32'(mag), 127);
        send_word(8'h01, 1'b0);
        chk_out("p1", 1'b0, 7'd1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            inp = 1'b1;
            in_valid = 1'b1;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_ir", 32'(in_ready), 1);
        chk("mid_rst_ov", 32'(out_valid), 0);
        chk("mid_rst_mag", 32'(mag), 0);
        chk("mid_rst_sign", 32'(sign), 0);
        send_word(8'hFF, 1'b0);
        chk_out("m1", 1'b1, 7'd1, 1'b0);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
